// File: rtl/gpu_pixel_writer.sv
// Pixel sink for the line rasterizer: clips off-screen pixels, buffers the rest in a
// small FIFO and issues one framebuffer write at a time over a req/ack handshake.
module gpu_pixel_writer #(
   parameter int unsigned WIDTH_BITS  = 10,
   parameter int unsigned HEIGHT_BITS = 9,
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480,
   parameter int unsigned COLOR_BITS  = 24,
   parameter int unsigned ADDR_BITS   = 19,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   pix_valid,
   input  logic [WIDTH_BITS-1:0]  pix_x,
   input  logic [HEIGHT_BITS-1:0] pix_y,
   input  logic [COLOR_BITS-1:0]  pix_color,
   output logic                   pix_ready,
   output logic                   mem_wr_req,
   output logic [ADDR_BITS-1:0]   mem_addr,
   output logic [COLOR_BITS-1:0]  mem_wdata,
   input  logic                   mem_wr_ack,
   output logic                   idle,
   output logic [7:0]             drop_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [WIDTH_BITS-1:0]  x;
      logic [HEIGHT_BITS-1:0] y;
      logic [COLOR_BITS-1:0]  color;
   } entry_t;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   entry_t               fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [7:0]           drop_count_q;
   state_t               state_q;
   logic                 mem_wr_req_q;
   logic [ADDR_BITS-1:0] mem_addr_q;
   logic [COLOR_BITS-1:0] mem_wdata_q;

   logic                 fifo_empty, fifo_full;
   logic                 in_range, accept, push, drop, pop;
   entry_t               head;
   logic [ADDR_BITS-1:0] head_addr;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

   assign in_range = ({1'b0, pix_x} < (WIDTH_BITS + 1)'(WIDTH)) &&
                     ({1'b0, pix_y} < (HEIGHT_BITS + 1)'(HEIGHT));
   assign accept   = pix_valid && !fifo_full;
   assign push     = accept && in_range;
   assign drop     = accept && !in_range;

   // IDLE pops whenever data is present; REQ pops only when the current write is acked.
   assign pop = !fifo_empty && ((state_q == S_IDLE) || mem_wr_ack);

   assign head      = fifo_q[rd_ptr_q];
   assign head_addr = ADDR_BITS'(BASE_ADDR)
                    + ADDR_BITS'(head.y) * ADDR_BITS'(WIDTH)
                    + ADDR_BITS'(head.x);

   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{x: pix_x, y: pix_y, color: pix_color};
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= S_IDLE;
         mem_wr_req_q <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  mem_wr_req_q <= 1'b1;
                  mem_addr_q   <= head_addr;
                  mem_wdata_q  <= head.color;
                  state_q      <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_wr_ack) begin
                  if (pop) begin
                     mem_addr_q  <= head_addr;
                     mem_wdata_q <= head.color;
                  end else begin
                     mem_wr_req_q <= 1'b0;
                     state_q      <= S_IDLE;
                  end
               end
            end
            default: begin
               mem_wr_req_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign pix_ready  = !fifo_full;
   assign mem_wr_req = mem_wr_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign idle       = (state_q == S_IDLE) && fifo_empty;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench for gpu_pixel_writer: a screen-level model predicts every framebuffer
// write and the drop counter; a negedge monitor checks writes as the DUT presents them.
module tb_gpu_pixel_writer;

   localparam int unsigned WB = 10, HB = 9, W = 640, H = 480, CB = 24, AB = 19;
   localparam int unsigned BASE = 0, DEPTH = 4;

   logic          clk = 1'b0;
   logic          n_rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic [WB-1:0] pix_x = '0;
   logic [HB-1:0] pix_y = '0;
   logic [CB-1:0] pix_color = '0;
   logic          pix_ready;
   logic          mem_wr_req;
   logic [AB-1:0] mem_addr;
   logic [CB-1:0] mem_wdata;
   logic          mem_wr_ack = 1'b0;
   logic          idle;
   logic [7:0]    drop_count;

   gpu_pixel_writer #(
      .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .WIDTH(W), .HEIGHT(H),
      .COLOR_BITS(CB), .ADDR_BITS(AB), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .n_rst(n_rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .pix_ready(pix_ready), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack),
      .idle(idle), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        cyc      = 0;
   int        n_acc    = 0;
   int        exp_drop = 0;
   int        ack_mode = 0;  // 0: low, 1: high, 2: toggle, 3: random
   bit        prod_done;
   logic [AB+CB-1:0] exp_q[$];
   int        wr_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always begin
      @(posedge clk);
      #2;
      case (ack_mode)
         0: mem_wr_ack = 1'b0;
         1: mem_wr_ack = 1'b1;
         2: mem_wr_ack = ~mem_wr_ack;
         default: mem_wr_ack = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: held requests must keep address/data; acked writes must match the model.
   logic          prev_hold = 1'b0;
   logic [AB-1:0] prev_addr;
   logic [CB-1:0] prev_data;
   always @(negedge clk) begin
      if (!n_rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_req", {63'b0, mem_wr_req}, 64'd1);
            chk("hold_addr_data", {mem_addr, mem_wdata}, {prev_addr, prev_data});
         end
         if (mem_wr_req && mem_wr_ack) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {mem_addr, mem_wdata}, '0);
               if ({mem_addr, mem_wdata} == '0) begin
                  n_fail++;
                  $display("FAIL unexpected_write: got a write with empty scoreboard");
               end
            end else begin
               chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
         end
         prev_hold = mem_wr_req && !mem_wr_ack;
         prev_addr = mem_addr;
         prev_data = mem_wdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: clip against the screen, else one linear framebuffer write.
   task automatic model_accept(input int unsigned x, input int unsigned y, input logic [CB-1:0] c);
      longint unsigned a;
      n_acc++;
      if (x >= W || y >= H) begin
         if (exp_drop < 255) exp_drop++;
      end else begin
         a = (longint'(BASE) + longint'(y) * W + x) % (64'd1 << AB);
         exp_q.push_back({AB'(a), c});
      end
   endtask

   task automatic send(input int unsigned x, input int unsigned y, input logic [CB-1:0] c);
      bit acc = 0;
      int t = 0;
      pix_x = WB'(x); pix_y = HB'(y); pix_color = c; pix_valid = 1'b1;
      while (!acc && t < 300) begin
         @(negedge clk);
         acc = pix_ready;
         t++;
         tick(1);
      end
      pix_valid = 1'b0;
      if (acc) model_accept(x, y, c);
      else chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(idle && exp_q.size() == 0) && t < 500) begin
         tick(1);
         t++;
      end
      chk("drain_idle", {63'b0, idle}, 64'd1);
      chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int nw;
      int t;
      #1 n_rst = 1'b0;
      #1;
      chk("rst_ready", {63'b0, pix_ready}, 64'd1);
      chk("rst_req", {63'b0, mem_wr_req}, 64'd0);
      chk("rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
      chk("rst_idle", {63'b0, idle}, 64'd1);
      chk("rst_drop", 64'(drop_count), 64'd0);
      tick(3);
      n_rst = 1'b1;
      tick(2);

      // Single pixel, ack held high: check two-cycle latency and address
      ack_mode = 1;
      send(3, 2, 24'hFF0000);
      chk("single_idle_falls", {63'b0, idle}, 64'd0);
      chk("single_req_not_yet", {63'b0, mem_wr_req}, 64'd0);
      tick(1);
      chk("single_req_up", {63'b0, mem_wr_req}, 64'd1);
      chk("single_addr", 64'(mem_addr), 64'd1283);
      wait_idle();

      // Clipped pixels never reach memory and leave idle asserted
      send(640, 0, 24'h1);
      chk("clip_idle", {63'b0, idle}, 64'd1);
      send(0, 480, 24'h2);
      send(1023, 511, 24'h3);
      tick(4);
      chk("clip_idle2", {63'b0, idle}, 64'd1);
      chk("clip_drop3", 64'(drop_count), 64'(exp_drop));
      chk("clip_drop3_const", 64'(drop_count), 64'd3);

      // Saturation
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) send($urandom_range(W, 1023), $urandom_range(0, 511), 24'($urandom));
         else            send($urandom_range(0, 1023), $urandom_range(H, 511), 24'($urandom));
      end
      tick(2);
      chk("drop_saturated", 64'(drop_count), 64'd255);

      // Backpressure: one write in flight plus a full FIFO, then release
      ack_mode = 0;
      tick(2);
      nw = n_acc;
      prod_done = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(10 + i, 20 + i, 24'hA00000 + 24'(i));
            prod_done = 1;
         end
      join_none
      tick(16);
      chk("bp_accepts", 64'(n_acc - nw), 64'(DEPTH + 1));
      chk("bp_ready_low", {63'b0, pix_ready}, 64'd0);
      chk("bp_addr_held", 64'(mem_addr), 64'(20 * W + 10));
      nw = wr_cyc.size();
      ack_mode = 1;
      t = 0;
      while (!prod_done && t < 100) begin tick(1); t++; end
      chk("bp_producer_done", {63'b0, prod_done}, 64'd1);
      wait_idle();
      chk("bp_writes", 64'(wr_cyc.size() - nw), 64'd6);
      if (wr_cyc.size() >= nw + 5) chk("bp_back_to_back", 64'(wr_cyc[nw+4] - wr_cyc[nw]), 64'd4);

      // Diagonal line with toggling ack: 0, 641, 1282, 1923
      ack_mode = 2;
      nw = wr_cyc.size();
      for (int i = 0; i < 4; i++) send(i, i, 24'h00FF00 + 24'(i));
      wait_idle();
      chk("diag_writes", 64'(wr_cyc.size() - nw), 64'd4);

      // Random mix with random ack, including screen-edge pixels
      ack_mode = 3;
      send(W - 1, H - 1, 24'h123456);
      send(0, H - 1, 24'h654321);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) send($urandom_range(0, 1023), $urandom_range(H, 511), 24'($urandom));
         else send($urandom_range(0, W - 1), $urandom_range(0, H - 1), 24'($urandom));
         if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 4));
      end
      ack_mode = 1;
      wait_idle();
      chk("rand_drop", 64'(drop_count), 64'(exp_drop));

      // Reset in the middle of a held request abandons it
      ack_mode = 0;
      tick(2);
      send(5, 5, 24'hBEEF00);
      tick(2);
      chk("midreq_req_up", {63'b0, mem_wr_req}, 64'd1);
      #2 n_rst = 1'b0;
      #1;
      chk("midreq_rst_req", {63'b0, mem_wr_req}, 64'd0);
      chk("midreq_rst_idle", {63'b0, idle}, 64'd1);
      chk("midreq_rst_ready", {63'b0, pix_ready}, 64'd1);
      chk("midreq_rst_drop", 64'(drop_count), 64'd0);
      exp_q.delete();
      exp_drop = 0;
      tick(2);
      n_rst = 1'b1;
      ack_mode = 1;
      nw = wr_cyc.size();
      tick(10);
      chk("midreq_no_retry", 64'(wr_cyc.size() - nw), 64'd0);
      chk("midreq_final_idle", {63'b0, idle}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
